// File: rtl/idu_scoreboard_pkg.sv
// Shared sizing and types for the decode->execute issue scoreboard.
package idu_scoreboard_pkg;

  localparam int REG_ADDRW       = 5;
  localparam int NUM_REGS        = 1 << REG_ADDRW;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [REG_ADDRW-1:0] reg_idx_t;

  // x0 is hardwired to zero, so it never carries a dependency.
  function automatic logic isTracked(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/idu_scoreboard_sb_counter.sv
// Small up/down occupancy counter. It holds at MAX_OUTSTANDING and at zero.
// A decrement at zero raises underflow_o for that cycle.
module sb_counter
  import idu_scoreboard_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output cnt_t count_o,
  output logic underflow_o
);

  cnt_t count_q;
  cnt_t count_d;
  logic underflow;

  // Next count: a simultaneous inc and dec cancel out, and both ends saturate.
  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (count_q != cnt_t'(MAX_OUTSTANDING)) begin
          count_d = count_q + 1'b1;
        end
      end
      2'b01: begin
        if (count_q == '0) begin
          underflow = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign underflow_o = underflow;

endmodule

// File: rtl/idu_scoreboard.sv
// Issue interlock between decode and execute. It counts in-flight writes for each GPR
// and the total number of instructions in flight. It stalls on RAW hazards, keeps system
// instructions serialised, and caps the number of outstanding instructions.
module idu_scoreboard
  import idu_scoreboard_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_pre_valid,
  output logic     o_pre_ready,
  input  reg_idx_t i_rs1id,
  input  logic     i_rs1_ren,
  input  reg_idx_t i_rs2id,
  input  logic     i_rs2_ren,
  input  reg_idx_t i_rdid,
  input  logic     i_rdwen,
  input  logic     i_sysins,
  output logic     o_post_valid,
  input  logic     i_post_ready,
  input  logic     i_wb_valid,
  input  reg_idx_t i_wb_rdid,
  input  logic     i_wb_rdwen,
  output logic     o_busy,
  output logic     o_stall,
  output logic     o_err
);

  logic                  hazard;
  logic                  issue;
  logic [NUM_REGS-1:0]   regBusy;
  logic [NUM_REGS-1:1]   regUnderflow;
  cnt_t                  totalCount;
  logic                  totalUnderflow;
  logic                  sysPend_q;
  logic                  sysPend_d;
  logic                  err_q;
  logic                  err_d;

  assign regBusy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    cnt_t regCount;
    logic regInc;
    logic regDec;

    assign regInc     = issue && i_rdwen && (i_rdid == reg_idx_t'(r));
    assign regDec     = i_wb_valid && i_wb_rdwen && (i_wb_rdid == reg_idx_t'(r));
    assign regBusy[r] = regCount != '0;

    sb_counter u_cnt (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .inc_i       (regInc),
      .dec_i       (regDec),
      .count_o     (regCount),
      .underflow_o (regUnderflow[r])
    );
  end

  sb_counter u_total (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .inc_i       (issue),
    .dec_i       (i_wb_valid),
    .count_o     (totalCount),
    .underflow_o (totalUnderflow)
  );

  // Hazard uses registered state only, so a retire frees an instruction one cycle later.
  always_comb begin
    hazard = 1'b0;
    if (i_rs1_ren && isTracked(i_rs1id) && regBusy[i_rs1id]) hazard = 1'b1;
    if (i_rs2_ren && isTracked(i_rs2id) && regBusy[i_rs2id]) hazard = 1'b1;
    if (i_sysins && (totalCount != '0))                      hazard = 1'b1;
    if (sysPend_q)                                           hazard = 1'b1;
    if (totalCount == cnt_t'(MAX_OUTSTANDING))               hazard = 1'b1;
  end

  assign issue        = i_pre_valid && i_post_ready && !hazard;
  assign o_post_valid = i_pre_valid && !hazard;
  assign o_pre_ready  = i_post_ready && !hazard;
  assign o_stall      = i_pre_valid && hazard;
  assign o_busy       = totalCount != '0;
  assign o_err        = err_q;

  // Next state for the sys_pend and err flags. A system instruction issues only when the
  // pipe is empty, so the next retire after it must be the system instruction itself.
  always_comb begin
    sysPend_d = sysPend_q;
    if (issue && i_sysins) begin
      sysPend_d = 1'b1;
    end else if (i_wb_valid) begin
      sysPend_d = 1'b0;
    end
    err_d = err_q || totalUnderflow || (|regUnderflow);
  end

  // Flag registers for system serialisation and the sticky underflow error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sysPend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sysPend_q <= sysPend_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_idu_scoreboard.sv
// Directed bench for idu_scoreboard. Each stimulus vector queues its expected outputs,
// and a monitor on the falling edge pops and compares them.
module tb_idu_scoreboard;
  import idu_scoreboard_pkg::*;

  typedef struct {
    string      tag;
    logic [4:0] v;   // {post_valid, pre_ready, stall, busy, err}
  } expect_t;

  logic     clock = 1'b0;
  logic     reset = 1'b1;
  logic     preValid = 1'b0;
  logic     preReady;
  reg_idx_t rs1 = '0;
  logic     rs1Ren = 1'b0;
  reg_idx_t rs2 = '0;
  logic     rs2Ren = 1'b0;
  reg_idx_t rd = '0;
  logic     rdWen = 1'b0;
  logic     sysIns = 1'b0;
  logic     postValid;
  logic     postReady = 1'b0;
  logic     wbValid = 1'b0;
  reg_idx_t wbRd = '0;
  logic     wbRdWen = 1'b0;
  logic     busy;
  logic     stall;
  logic     err;

  expect_t expQ[$];
  int      totalCount = 0;
  int      badCount = 0;

  always #5 clock = ~clock;

  idu_scoreboard dut (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_pre_valid  (preValid),
    .o_pre_ready  (preReady),
    .i_rs1id      (rs1),
    .i_rs1_ren    (rs1Ren),
    .i_rs2id      (rs2),
    .i_rs2_ren    (rs2Ren),
    .i_rdid       (rd),
    .i_rdwen      (rdWen),
    .i_sysins     (sysIns),
    .o_post_valid (postValid),
    .i_post_ready (postReady),
    .i_wb_valid   (wbValid),
    .i_wb_rdid    (wbRd),
    .i_wb_rdwen   (wbRdWen),
    .o_busy       (busy),
    .o_stall      (stall),
    .o_err        (err)
  );

  // Compares one output field and records the result.
  task automatic checkOutput(input string tag, input string field, input logic actual,
                             input logic expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s.%s got=%b want=%b", tag, field, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, queues the expected outputs, and advances past the edge.
  task automatic applyStimulus(input string tag, input logic pv, input reg_idx_t r1,
                               input logic r1en, input reg_idx_t r2, input logic r2en,
                               input reg_idx_t d, input logic dwen, input logic sys,
                               input logic prdy, input logic wbv, input reg_idx_t wbd,
                               input logic wbw, input logic [4:0] expv);
    expect_t e;
    preValid  = pv;
    rs1       = r1;
    rs1Ren    = r1en;
    rs2       = r2;
    rs2Ren    = r2en;
    rd        = d;
    rdWen     = dwen;
    sysIns    = sys;
    postReady = prdy;
    wbValid   = wbv;
    wbRd      = wbd;
    wbRdWen   = wbw;
    e.tag = tag;
    e.v   = expv;
    expQ.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: checks the outputs mid-cycle against the oldest queued expectation.
  always @(negedge clock) begin
    if (expQ.size() != 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput(e.tag, "post_valid", postValid, e.v[4]);
      checkOutput(e.tag, "pre_ready",  preReady,  e.v[3]);
      checkOutput(e.tag, "stall",      stall,     e.v[2]);
      checkOutput(e.tag, "busy",       busy,      e.v[1]);
      checkOutput(e.tag, "err",        err,       e.v[0]);
    end
  end

  // Directed sequence. The last argument is {post_valid, pre_ready, stall, busy, err}.
  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Out of reset with rs1=5 offered: passes straight through.
    applyStimulus("t1_reset", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10000);

    // RAW on x5: the consumer is held through the retire cycle and issues on the next cycle.
    applyStimulus("t2_issue_rd5",  1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t2_raw_stall",  1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0, 5'b00110);
    applyStimulus("t2_retire_cyc", 1, 5, 1, 0, 0, 6, 1, 0, 1, 1, 5, 1, 5'b00110);
    applyStimulus("t2_issue_after",1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t2_drain",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00010);

    // Outstanding cap: four in flight, the fifth waits until one retires.
    applyStimulus("t3_rd1",    1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t3_rd2",    1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 5'b11010);
    applyStimulus("t3_rd3",    1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 5'b11010);
    applyStimulus("t3_rd4",    1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 5'b11010);
    applyStimulus("t3_full",   1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 5'b00110);
    applyStimulus("t3_retire", 1, 0, 0, 0, 0, 6, 1, 0, 1, 1, 1, 1, 5'b00110);
    applyStimulus("t3_issue5", 1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 0, 5'b11010);
    applyStimulus("t3_drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 5'b00010);
    applyStimulus("t3_drain3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 5'b00010);
    applyStimulus("t3_drain4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 5'b00010);
    applyStimulus("t3_drain6", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 5'b00010);

    // System serialisation: sysins waits for an empty pipe, then blocks everything behind it.
    applyStimulus("t4_rd7",        1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t4_sys_wait",   1, 0, 0, 0, 0, 9, 1, 1, 1, 0, 0, 0, 5'b00110);
    applyStimulus("t4_sys_wait_rt",1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 7, 1, 5'b00110);
    applyStimulus("t4_sys_issue",  1, 0, 0, 0, 0, 9, 1, 1, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t4_rd8_blk",    1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 5'b00110);
    applyStimulus("t4_rd8_blk_rt", 1, 0, 0, 0, 0, 8, 1, 0, 1, 1, 9, 1, 5'b00110);
    applyStimulus("t4_rd8_issue",  1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t4_drain",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 1, 5'b00010);

    // Same-cycle issue and retire of x3: the count stays at one, so an rs2 read of x3 still stalls.
    applyStimulus("t5_rd3",        1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t5_same_cycle", 1, 0, 0, 0, 0, 3, 1, 0, 1, 1, 3, 1, 5'b11010);
    applyStimulus("t5_rs2_stall",  1, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 5'b00110);
    applyStimulus("t5_rs2_stall_rt",1,0, 0, 3, 1, 0, 0, 0, 1, 1, 3, 1, 5'b00110);
    applyStimulus("t5_rs2_free",   1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 5'b10000);

    // Retire with nothing in flight: err becomes sticky and reset clears it.
    applyStimulus("t6_underflow",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 5'b00000);
    applyStimulus("t6_err_set",    1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10001);
    applyStimulus("t6_err_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus("t6_err_clear",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);

    // x0 traffic: never stalls and never touches a counter, so a retire of x0 raises no error.
    applyStimulus("t7_x0_a",    1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 5'b11000);
    applyStimulus("t7_x0_b",    1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 5'b11010);
    applyStimulus("t7_x0_rt_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00010);
    applyStimulus("t7_x0_rt_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00010);
    applyStimulus("t7_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clock);
    if (expQ.size() != 0) begin
      totalCount++;
      badCount++;
      $display("[TB] FAIL drain_queue got=%0d want=0", expQ.size());
    end
    #2;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
